// File: rtl/oled_seq_pkg.sv
// oled_seq_pkg: shared definitions for the PMOD OLED power sequencer.
//   state_t         sequencer states
//   INIT_A / INIT_B power-up command bytes, sent before and after VBAT is enabled
//   SHUT            power-down command byte
//   FAST_DELAY      length of every delay state when OLED_SEQ_FAST_SIM_EN is defined
//   rom_byte/rom_last/is_rom  helpers that select the command table for a state
package oled_seq_pkg;

  typedef enum logic [3:0] {
    ST_OFF       = 4'd0,
    ST_VDD_WAIT  = 4'd1,
    ST_RES_LOW   = 4'd2,
    ST_RES_HOLD  = 4'd3,
    ST_CMD_A     = 4'd4,
    ST_VBAT_WAIT = 4'd5,
    ST_CMD_B     = 4'd6,
    ST_READY     = 4'd7,
    ST_SHUT_CMD  = 4'd8,
    ST_SHUT_VBAT = 4'd9
  } state_t;

  localparam int INIT_A_LEN = 5;
  localparam int INIT_B_LEN = 5;
  localparam int SHUT_LEN   = 1;

  localparam logic [7:0] INIT_A [INIT_A_LEN] = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1};
  localparam logic [7:0] INIT_B [INIT_B_LEN] = '{8'hA1, 8'hC8, 8'hDA, 8'h20, 8'hAF};
  localparam logic [7:0] SHUT   [SHUT_LEN]   = '{8'hAE};

  localparam int FAST_DELAY = 16;

  function automatic logic is_rom(input state_t st);
    is_rom = (st == ST_CMD_A) || (st == ST_CMD_B) || (st == ST_SHUT_CMD);
  endfunction

  function automatic logic [7:0] rom_byte(input state_t st, input logic [2:0] idx);
    logic [7:0] b;
    case (st)
      ST_CMD_A: b = INIT_A[idx];
      ST_CMD_B: b = INIT_B[idx];
      default:  b = SHUT[0];
    endcase
    rom_byte = b;
  endfunction

  function automatic logic rom_last(input state_t st, input logic [2:0] idx);
    logic l;
    case (st)
      ST_CMD_A: l = (idx == 3'(INIT_A_LEN - 1));
      ST_CMD_B: l = (idx == 3'(INIT_B_LEN - 1));
      default:  l = (idx == 3'(SHUT_LEN - 1));
    endcase
    rom_last = l;
  endfunction

endpackage

// File: rtl/oled_power_sequencer_if.sv
// oled_power_sequencer_if: byte streams around the sequencer.
//   host_valid/host_data/host_dc/host_ready  byte stream from the UART command decoder
//   spi_valid/spi_data/spi_ready             byte stream into the SPI shifter
// Modports: slave = the sequencer, master = the surrounding logic (decoder + shifter).
interface oled_power_sequencer_if;
  logic       host_valid;
  logic [7:0] host_data;
  logic       host_dc;
  logic       host_ready;
  logic       spi_valid;
  logic [7:0] spi_data;
  logic       spi_ready;

  modport slave (
    input  host_valid, host_data, host_dc, spi_ready,
    output host_ready, spi_valid, spi_data
  );

  modport master (
    output host_valid, host_data, host_dc, spi_ready,
    input  host_ready, spi_valid, spi_data
  );
endinterface

// File: rtl/oled_delay_timer.sv
// oled_delay_timer: loadable down-counter for the sequencer delay states.
//   clk, rst_n   clock, asynchronous active-low reset
//   load         load load_val this cycle (takes priority over counting)
//   load_val     cycles remaining minus one
//   done         high while the count is zero
module oled_delay_timer #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - W'(1);
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/oled_power_sequencer.sv
// oled_power_sequencer: PMOD OLED power-up / power-down sequencer.
//   clk, resetq       clock, asynchronous active-low reset
//   start, shutdown   single-cycle requests (shutdown wins when both arrive)
//   bus (slave)       host byte stream in, SPI shifter byte stream out
//   PMOD_CS/DC/RES/VBATC/VDDC  panel control pins (CS, RES, VBATC, VDDC active-low)
//   panel_on          high only while host traffic is passed to the shifter
// Build option: OLED_SEQ_FAST_SIM_EN makes every delay state last FAST_DELAY cycles.
module oled_power_sequencer
  import oled_seq_pkg::*;
#(
  parameter int MHZ       = 12,
  parameter int T_VDD_US  = 1000,
  parameter int T_RES_US  = 3,
  parameter int T_VBAT_MS = 100
) (
  input  logic                        clk,
  input  logic                        resetq,
  input  logic                        start,
  input  logic                        shutdown,
  oled_power_sequencer_if.slave       bus,
  output logic                        PMOD_CS,
  output logic                        PMOD_DC,
  output logic                        PMOD_RES,
  output logic                        PMOD_VBATC,
  output logic                        PMOD_VDDC,
  output logic                        panel_on
);

  localparam int TMR_W = $clog2(T_VBAT_MS * MHZ * 1000 + 1);

`ifdef OLED_SEQ_FAST_SIM_EN
  localparam int D_VDD  = FAST_DELAY;
  localparam int D_RES  = FAST_DELAY;
  localparam int D_VBAT = FAST_DELAY;
`else
  localparam int D_VDD  = T_VDD_US * MHZ;
  localparam int D_RES  = T_RES_US * MHZ;
  localparam int D_VBAT = T_VBAT_MS * MHZ * 1000;
`endif

  // The timer is loaded on the entry edge, so a state lasting N cycles loads N-1.
  localparam logic [TMR_W-1:0] LD_VDD  = TMR_W'(D_VDD - 1);
  localparam logic [TMR_W-1:0] LD_RES  = TMR_W'(D_RES - 1);
  localparam logic [TMR_W-1:0] LD_VBAT = TMR_W'(D_VBAT - 1);

  state_t             state, state_d;
  logic [2:0]         idx;
  logic               gap;
  logic               shut_pend;
  logic               tmr_load, tmr_done;
  logic [TMR_W-1:0]   tmr_val;
  logic               rom_valid, spi_valid_c, xfer, busy, req, early, late;

  oled_delay_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (resetq),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Byte source: ROM while sequencing, host pass-through once READY.
  // gap forces one idle cycle after each ROM transfer so the shifter can go busy.
  assign rom_valid      = is_rom(state) && !gap;
  assign spi_valid_c    = (state == ST_READY) ? bus.host_valid : rom_valid;
  assign bus.spi_valid  = spi_valid_c;
  assign bus.spi_data   = (state == ST_READY) ? bus.host_data : rom_byte(state, idx);
  assign bus.host_ready = (state == ST_READY) && bus.spi_ready;
  assign panel_on       = (state == ST_READY);

  assign xfer  = spi_valid_c && bus.spi_ready;
  // An offered byte that has not transferred yet must finish before shutting down.
  assign busy  = spi_valid_c && !bus.spi_ready;
  assign req   = shutdown || shut_pend;
  assign early = (state == ST_VDD_WAIT) || (state == ST_RES_LOW) ||
                 (state == ST_RES_HOLD) || (state == ST_CMD_A);
  assign late  = (state == ST_VBAT_WAIT) || (state == ST_CMD_B) || (state == ST_READY);

  always_comb begin
    state_d = state;
    if (early && req && !busy) begin
      state_d = ST_OFF;         // VBAT never came on, so drop straight to OFF
    end else if (late && req && !busy) begin
      state_d = ST_SHUT_CMD;
    end else begin
      case (state)
        ST_OFF:       if (start && !shutdown)               state_d = ST_VDD_WAIT;
        ST_VDD_WAIT:  if (tmr_done)                         state_d = ST_RES_LOW;
        ST_RES_LOW:   if (tmr_done)                         state_d = ST_RES_HOLD;
        ST_RES_HOLD:  if (tmr_done)                         state_d = ST_CMD_A;
        ST_CMD_A:     if (xfer && rom_last(state, idx))     state_d = ST_VBAT_WAIT;
        ST_VBAT_WAIT: if (tmr_done)                         state_d = ST_CMD_B;
        ST_CMD_B:     if (xfer && rom_last(state, idx))     state_d = ST_READY;
        ST_SHUT_CMD:  if (xfer && rom_last(state, idx))     state_d = ST_SHUT_VBAT;
        ST_SHUT_VBAT: if (tmr_done)                         state_d = ST_OFF;
        default:                                            state_d = state;
      endcase
    end
  end

  always_comb begin
    tmr_load = (state_d != state);
    case (state_d)
      ST_VDD_WAIT:                tmr_val = LD_VDD;
      ST_RES_LOW, ST_RES_HOLD:    tmr_val = LD_RES;
      ST_VBAT_WAIT, ST_SHUT_VBAT: tmr_val = LD_VBAT;
      default:                    tmr_val = '0;
    endcase
  end

  // Pins are registered from the next state so they switch on the entry edge.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state      <= ST_OFF;
      idx        <= '0;
      gap        <= 1'b0;
      shut_pend  <= 1'b0;
      PMOD_CS    <= 1'b1;
      PMOD_DC    <= 1'b0;
      PMOD_RES   <= 1'b1;
      PMOD_VBATC <= 1'b1;
      PMOD_VDDC  <= 1'b1;
    end else begin
      state     <= state_d;
      shut_pend <= (early || late) && req && busy;
      if (state_d != state) begin
        idx <= '0;
        gap <= 1'b0;
      end else if (xfer && is_rom(state)) begin
        idx <= idx + 3'd1;
        gap <= 1'b1;
      end else begin
        gap <= 1'b0;
      end
      // DC follows the byte that starts shifting, so it only moves at a transfer.
      if (xfer) PMOD_DC <= (state == ST_READY) ? bus.host_dc : 1'b0;
      PMOD_VDDC  <= (state_d == ST_OFF);
      PMOD_CS    <= (state_d == ST_OFF);
      PMOD_RES   <= (state_d != ST_RES_LOW);
      PMOD_VBATC <= !((state_d == ST_VBAT_WAIT) || (state_d == ST_CMD_B) ||
                      (state_d == ST_READY)     || (state_d == ST_SHUT_CMD));
    end
  end

endmodule

// File: tb/tb_oled_power_sequencer.sv
// tb_oled_power_sequencer: scoreboard bench for oled_power_sequencer.
// Stimulus pushes expected events (pin edges, byte transfers, cycle gaps between
// events) into a queue; a negedge monitor pops and compares each DUT event.
// Honours OLED_SEQ_FAST_SIM_EN (16-cycle delays); otherwise uses small parameters.
`timescale 1ns/1ps
module tb_oled_power_sequencer;

`ifdef OLED_SEQ_FAST_SIM_EN
  localparam int D_VDD  = 16;
  localparam int D_RES  = 16;
  localparam int D_VBAT = 16;
`else
  localparam int D_VDD  = 20;    // T_VDD_US=20 at 1 MHz
  localparam int D_RES  = 4;     // T_RES_US=4
  localparam int D_VBAT = 1000;  // T_VBAT_MS=1
`endif
  localparam int BUD = 3 * D_VBAT + 500;

  localparam logic [7:0] T_BYTE  = 8'd1;
  localparam logic [7:0] T_DC    = 8'd2;
  localparam logic [7:0] T_VDDC  = 8'd3;
  localparam logic [7:0] T_RES   = 8'd4;
  localparam logic [7:0] T_VBATC = 8'd5;
  localparam logic [7:0] T_CS    = 8'd6;
  localparam logic [7:0] T_PANEL = 8'd7;

  typedef struct {
    logic [7:0] tag;
    logic [7:0] val;
    int         gap;
  } ev_t;

  logic clk = 1'b0;
  logic resetq, start, shutdown;
  logic PMOD_CS, PMOD_DC, PMOD_RES, PMOD_VBATC, PMOD_VDDC, panel_on;

  oled_power_sequencer_if bus();

  oled_power_sequencer #(
    .MHZ(1), .T_VDD_US(20), .T_RES_US(4), .T_VBAT_MS(1)
  ) dut (
    .clk        (clk),
    .resetq     (resetq),
    .start      (start),
    .shutdown   (shutdown),
    .bus        (bus),
    .PMOD_CS    (PMOD_CS),
    .PMOD_DC    (PMOD_DC),
    .PMOD_RES   (PMOD_RES),
    .PMOD_VBATC (PMOD_VBATC),
    .PMOD_VDDC  (PMOD_VDDC),
    .panel_on   (panel_on)
  );

  always #5 clk = ~clk;

  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  last_cyc = 0;
  bit  mon_en = 1'b0;
  logic p_vddc, p_cs, p_res, p_vbatc, p_dc, p_panel;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string tname(input logic [7:0] t);
    case (t)
      T_BYTE:  return "byte";
      T_DC:    return "PMOD_DC";
      T_VDDC:  return "PMOD_VDDC";
      T_RES:   return "PMOD_RES";
      T_VBATC: return "PMOD_VBATC";
      T_CS:    return "PMOD_CS";
      T_PANEL: return "panel_on";
      default: return "?";
    endcase
  endfunction

  task automatic push(input logic [7:0] tag, input logic [7:0] val, input int gap);
    ev_t e;
    e.tag = tag; e.val = val; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic observe(input logic [7:0] tag, input logic [7:0] val);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected %s event: got %h at cycle %0d, required no event", tname(tag), val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.tag !== tag || e.val !== val) begin
        n_err++;
        $display("FAIL event order: got %s=%h, required %s=%h (cycle %0d)",
                 tname(tag), val, tname(e.tag), e.val, cyc);
      end else if (e.gap >= 0) begin
        n_vec++;
        if (cyc - last_cyc != e.gap) begin
          n_err++;
          $display("FAIL %s=%h timing: got %0d cycles after previous event, required %0d",
                   tname(tag), val, cyc - last_cyc, e.gap);
        end
      end
    end
    last_cyc = cyc;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (PMOD_VDDC  !== p_vddc)  observe(T_VDDC,  {7'd0, PMOD_VDDC});
      if (PMOD_CS    !== p_cs)    observe(T_CS,    {7'd0, PMOD_CS});
      if (PMOD_RES   !== p_res)   observe(T_RES,   {7'd0, PMOD_RES});
      if (PMOD_VBATC !== p_vbatc) observe(T_VBATC, {7'd0, PMOD_VBATC});
      if (PMOD_DC    !== p_dc)    observe(T_DC,    {7'd0, PMOD_DC});
      if (panel_on   !== p_panel) observe(T_PANEL, {7'd0, panel_on});
      if (bus.spi_valid === 1'b1 && bus.spi_ready === 1'b1) observe(T_BYTE, bus.spi_data);
    end else begin
      last_cyc = cyc;
    end
    p_vddc = PMOD_VDDC; p_cs = PMOD_CS; p_res = PMOD_RES;
    p_vbatc = PMOD_VBATC; p_dc = PMOD_DC; p_panel = panel_on;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_bit(input string name, input logic got, input logic want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %b, required %b", name, got, want);
    end
  endtask

  task automatic chk_byte(input string name, input logic [7:0] got, input logic [7:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic drain(input int budget, input string what);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s timeout: %0d expected events outstanding, required 0", what, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_valid(input int budget, input string what);
    int n;
    n = 0;
    while (bus.spi_valid !== 1'b1 && n < budget) begin
      step(1);
      n++;
    end
    n_vec++;
    if (bus.spi_valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s: spi_valid=%b after %0d cycles, required 1", what, bus.spi_valid, n);
    end
  endtask

  task automatic push_front_half();
    push(T_VDDC, 8'd0, -1);
    push(T_CS,   8'd0, 0);
    push(T_RES,  8'd0, D_VDD);
    push(T_RES,  8'd1, D_RES);
  endtask

  task automatic push_cmd_a();
    push(T_BYTE, 8'hAE, D_RES);
    push(T_BYTE, 8'h8D, 2);
    push(T_BYTE, 8'h14, 2);
    push(T_BYTE, 8'hD9, 2);
    push(T_BYTE, 8'hF1, 2);
    push(T_VBATC, 8'd0, 1);
  endtask

  task automatic push_cmd_b();
    push(T_BYTE, 8'hA1, D_VBAT);
    push(T_BYTE, 8'hC8, 2);
    push(T_BYTE, 8'hDA, 2);
    push(T_BYTE, 8'h20, 2);
    push(T_BYTE, 8'hAF, 2);
    push(T_PANEL, 8'd1, 1);
  endtask

  initial begin
    int n;
    resetq = 1'b0; start = 1'b0; shutdown = 1'b0;
    bus.host_valid = 1'b0; bus.host_data = 8'h00; bus.host_dc = 1'b0; bus.spi_ready = 1'b1;
    step(3);
    chk_bit("reset PMOD_CS", PMOD_CS, 1'b1);
    chk_bit("reset PMOD_DC", PMOD_DC, 1'b0);
    chk_bit("reset PMOD_RES", PMOD_RES, 1'b1);
    chk_bit("reset PMOD_VBATC", PMOD_VBATC, 1'b1);
    chk_bit("reset PMOD_VDDC", PMOD_VDDC, 1'b1);
    chk_bit("reset spi_valid", bus.spi_valid, 1'b0);
    chk_bit("reset host_ready", bus.host_ready, 1'b0);
    chk_bit("reset panel_on", panel_on, 1'b0);
    resetq = 1'b1;
    step(2);
    mon_en = 1'b1;
    step(1);

    // Full power-up with the shifter always ready
    push_front_half(); push_cmd_a(); push_cmd_b();
    start = 1'b1; step(1); start = 1'b0;
    drain(BUD, "power-up");
    chk_bit("ready panel_on", panel_on, 1'b1);
    chk_bit("ready PMOD_VBATC", PMOD_VBATC, 1'b0);

    // Host pass-through with shifter back-pressure
    bus.host_valid = 1'b1; bus.host_data = 8'h55; bus.host_dc = 1'b1; bus.spi_ready = 1'b0;
    push(T_BYTE, 8'h55, -1); push(T_DC, 8'd1, 1);
    #1;
    chk_byte("pass-through spi_data", bus.spi_data, 8'h55);
    chk_bit("pass-through spi_valid", bus.spi_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk_bit("host_ready while shifter busy", bus.host_ready, 1'b0);
    end
    bus.spi_ready = 1'b1;
    #1;
    chk_bit("host_ready follows spi_ready", bus.host_ready, 1'b1);
    step(1);
    bus.host_data = 8'hB0; bus.host_dc = 1'b0; bus.spi_ready = 1'b0;
    push(T_BYTE, 8'hB0, -1); push(T_DC, 8'd0, 1);
    chk_bit("DC after 0x55 transfer", PMOD_DC, 1'b1);
    step(2);
    chk_bit("DC held before 0xB0 transfer", PMOD_DC, 1'b1);
    bus.spi_ready = 1'b1;
    step(1);
    bus.host_valid = 1'b0;
    step(1);
    drain(50, "host bytes");
    chk_bit("DC after 0xB0 transfer", PMOD_DC, 1'b0);

    // Shutdown from READY
    push(T_PANEL, 8'd0, -1); push(T_BYTE, 8'hAE, 0); push(T_VBATC, 8'd1, 1);
    push(T_VDDC, 8'd1, D_VBAT); push(T_CS, 8'd1, 0);
    shutdown = 1'b1; step(1); shutdown = 1'b0;
    drain(BUD, "power-down");
    chk_bit("off panel_on", panel_on, 1'b0);
    chk_bit("off PMOD_DC", PMOD_DC, 1'b0);

    // start and shutdown together from OFF: nothing happens
    start = 1'b1; shutdown = 1'b1; step(1); start = 1'b0; shutdown = 1'b0;
    step(D_VDD + 10);
    chk_bit("start+shutdown PMOD_VDDC", PMOD_VDDC, 1'b1);
    chk_bit("start+shutdown PMOD_CS", PMOD_CS, 1'b1);

    // Shutdown during CMD_A while 8D is held off by the shifter
    bus.spi_ready = 1'b0;
    push_front_half(); push(T_BYTE, 8'hAE, D_RES);
    start = 1'b1; step(1); start = 1'b0;
    wait_valid(BUD, "first CMD_A byte");
    bus.spi_ready = 1'b1; step(1); bus.spi_ready = 1'b0;
    wait_valid(10, "second CMD_A byte");
    chk_byte("second CMD_A byte", bus.spi_data, 8'h8D);
    push(T_BYTE, 8'h8D, 7); push(T_VDDC, 8'd1, 1); push(T_CS, 8'd1, 0);
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (i == 1) shutdown = 1'b1;
      if (i == 2) shutdown = 1'b0;
      chk_bit("8D held while pending shutdown", bus.spi_valid, 1'b1);
    end
    bus.spi_ready = 1'b1;
    step(1);
    step(10);
    drain(20, "early shutdown");
    chk_bit("early shutdown spi_valid", bus.spi_valid, 1'b0);
    chk_bit("early shutdown PMOD_VBATC", PMOD_VBATC, 1'b1);
    chk_bit("early shutdown PMOD_RES", PMOD_RES, 1'b1);

    // Power-up with host_valid held, then async reset in VBAT_WAIT
    bus.host_valid = 1'b1; bus.host_data = 8'h3C; bus.host_dc = 1'b1;
    push_front_half(); push_cmd_a();
    start = 1'b1; step(1); start = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < BUD) begin
      step(1);
      n++;
      chk_bit("host_ready before READY", bus.host_ready, 1'b0);
    end
    drain(1, "power-up to VBAT_WAIT");
    step(3);
    chk_bit("VBAT_WAIT PMOD_VBATC", PMOD_VBATC, 1'b0);
    push(T_VDDC, 8'd1, -1); push(T_CS, 8'd1, 0); push(T_VBATC, 8'd1, 0);
    #2 resetq = 1'b0;
    #1;
    chk_bit("async reset PMOD_VBATC", PMOD_VBATC, 1'b1);
    chk_bit("async reset PMOD_VDDC", PMOD_VDDC, 1'b1);
    chk_bit("async reset PMOD_CS", PMOD_CS, 1'b1);
    chk_bit("async reset host_ready", bus.host_ready, 1'b0);
    step(2);
    resetq = 1'b1;
    step(2);
    drain(10, "async reset");
    bus.host_valid = 1'b0;
    step(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
